sram_port0_ctrl: RTL and testbench

- Request/response front-end driving the RW port (port 0) of the 32x512 byte-masked OpenRAM macro.
- Converts a valid/ready request stream into registered macro pin activity: csb0, web0, wmask0, addr0 and din0.
- Captures dout0 one cycle after the macro samples its pins, and returns read data through a credited response FIFO so upstream back-pressure never loses data.
- Sits between the bus adapter (upstream) and the macro (downstream); shares the macro's clk0.

---
 rtl/sram_port0_ctrl.sv | 134 +++++++++++++
 tb/tb_sram_port0_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port0_ctrl.sv
// sram_port0_ctrl: valid/ready front-end for OpenRAM port 0 with a credited response FIFO.
// Optional write acknowledges: define SRAM_PORT0_CTRL_WACK_EN.
module sram_port0_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_wr,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 3) + 1;
  localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(RSP_DEPTH);

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  tag_in;
  logic                  credit_ok;
  logic [1:0]            tag_v;
  logic [CW-1:0]         count;
  logic [CW-1:0]         outstanding;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];

  assign accept      = req_valid & req_ready;
  assign pop         = rsp_valid & rsp_ready;
  assign push        = tag_v[1];
  assign rsp_valid   = (count != '0);
  assign outstanding = count + CW'(tag_v[0]) + CW'(tag_v[1]);
  assign credit_ok   = (outstanding - CW'(pop)) < DEPTH;
  assign rsp_rdata   = rsp_valid ? mem[rd_ptr] : '0;

`ifdef SRAM_PORT0_CTRL_WACK_EN
  logic [1:0] tag_w;
  logic       wr_mem [RSP_DEPTH];

  assign tag_in    = accept;
  assign req_ready = rstb0 & credit_ok;
  assign push_data = tag_w[1] ? '0 : dout0;
  assign rsp_wr    = rsp_valid & wr_mem[rd_ptr];

  // Marks which in-flight slots are write acknowledges
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) tag_w <= '0;
    else        tag_w <= {tag_w[0], accept & req_we};
  end

  // Ack flag stored alongside each FIFO entry
  always_ff @(posedge clk0) begin
    if (push) wr_mem[wr_ptr] <= tag_w[1];
  end
`else
  assign tag_in    = accept & ~req_we;
  assign req_ready = rstb0 & (req_we | credit_ok);
  assign push_data = dout0;
  assign rsp_wr    = 1'b0;
`endif

  // Pin stage: macro pins registered from the accepted request
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      addr0  <= '0;
      din0   <= '0;
    end else if (accept) begin
      csb0   <= 1'b0;
      web0   <= ~req_we;
      wmask0 <= req_we ? req_wmask : '0;
      addr0  <= req_addr;
      din0   <= req_wdata;
    end else begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
    end
  end

  // In-flight tags: stage 1 = macro sampling, stage 2 = dout0 capture
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) tag_v <= '0;
    else        tag_v <= {tag_v[0], tag_in};
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Response FIFO storage; head is shown combinationally
  always_ff @(posedge clk0) begin
    if (push) mem[wr_ptr] <= push_data;
  end

`ifdef SIMULATION
  // Credits make overflow unreachable; flag it if it ever happens
  always_ff @(posedge clk0) begin
    if (rstb0 && push && !pop && count == DEPTH)
      $error("sram_port0_ctrl: response FIFO overflow");
  end
`endif

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// tb_sram_port0_ctrl: directed + random checks against a queue-based model.
// Includes a behavioural model of the OpenRAM port 0 macro.
module tb_sram_port0_ctrl;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NM = 4;
  localparam int DEPTH = 4;
`ifdef SRAM_PORT0_CTRL_WACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic          clk0 = 1'b0;
  logic          rstb0 = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [NM-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_wr;
  logic          csb0;
  logic          web0;
  logic [NM-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  always #5 clk0 = ~clk0;

  sram_port0_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk0(clk0), .rstb0(rstb0),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_wr(rsp_wr),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0)
  );

  // Macro model: pins sampled on rising edge, array access on falling edge
  logic [DW-1:0] macro_mem [1<<AW];
  logic          m_csb = 1'b1;
  logic          m_web = 1'b1;
  logic [NM-1:0] m_wmask;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  always @(posedge clk0) begin
    m_csb   <= csb0;
    m_web   <= web0;
    m_wmask <= wmask0;
    m_addr  <= addr0;
    m_din   <= din0;
  end

  always @(negedge clk0) begin
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < NM; b++)
          if (m_wmask[b]) macro_mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
      end else begin
        dout0 <= macro_mem[m_addr];
      end
    end
  end

  // Reference model
  typedef struct {
    logic [DW-1:0] data;
    bit            wr;
    int            due;
  } exp_t;

  logic [DW-1:0] ref_mem [1<<AW];
  exp_t expq[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int nacc = 0;
  int npop = 0;
  int first_pop = 0;
  int last_pop = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit v, input bit we, input logic [NM-1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_wmask = m;
    req_addr  = a;
    req_wdata = d;
  endtask

  // One clock: check handshake-level behaviour at the falling edge
  task automatic cycle();
    bit   pp;
    bit   rdy_exp;
    bit   v_exp;
    exp_t e;
    @(negedge clk0);
    if (rstb0) begin
      pp      = rsp_valid & rsp_ready;
      v_exp   = (expq.size() > 0) && (expq[0].due <= cyc);
      rdy_exp = (req_we && !WACK) || ((expq.size() - int'(pp)) < DEPTH);
      chk("rsp_valid", rsp_valid, v_exp);
      chk("req_ready", req_ready, rdy_exp);
      if (pp) begin
        if (npop == 0) first_pop = cyc;
        npop++;
        last_pop = cyc;
        if (expq.size() == 0) begin
          chk("rsp_extra", 64'(expq.size()), 64'd1);
        end else begin
          e = expq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.data);
          chk("rsp_wr", rsp_wr, e.wr);
        end
      end
      if (req_valid && req_ready) begin
        nacc++;
        if (req_we) begin
          for (int b = 0; b < NM; b++)
            if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          if (WACK) expq.push_back('{data: '0, wr: 1'b1, due: cyc + 3});
        end else begin
          expq.push_back('{data: ref_mem[req_addr], wr: 1'b0, due: cyc + 3});
        end
      end
    end else begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end
    @(posedge clk0);
    cyc++;
    #1;
  endtask

  task automatic drain();
    set_req(0, 0, '0, '0, '0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && expq.size() > 0; i++) cycle();
    chk("drain_empty", 64'(expq.size()), 64'd0);
    cycle();
    cycle();
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      macro_mem[i] = v;
      ref_mem[i] = v;
    end

    // Reset state
    rstb0 = 1'b0;
    repeat (3) cycle();
    chk("rst_csb0", csb0, 1);
    chk("rst_web0", web0, 1);
    chk("rst_wmask0", wmask0, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_rsp_wr", rsp_wr, 0);
    rstb0 = 1'b1;
    cycle();
    chk("ready_after_rst", req_ready, 1);

    // Write then read, latency 2
    rsp_ready = 1'b1;
    set_req(1, 1, 4'hF, 9'h1A5, 32'hDEADBEEF);
    cycle();
    chk("w_csb0", csb0, 0);
    chk("w_web0", web0, 0);
    chk("w_addr0", addr0, 9'h1A5);
    chk("w_din0", din0, 32'hDEADBEEF);
    chk("w_wmask0", wmask0, 4'hF);
    set_req(1, 0, 4'hF, 9'h1A5, 32'h0);
    cycle();
    chk("r_csb0", csb0, 0);
    chk("r_web0", web0, 1);
    chk("r_wmask0", wmask0, 0);
    set_req(0, 0, '0, '0, '0);
    cycle();
    chk("lat_k1_valid", rsp_valid, WACK);
    cycle();
    chk("lat_k2_valid", rsp_valid, 1);
    chk("lat_k2_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("idle_csb0", csb0, 1);
    drain();

    // Byte mask
    set_req(1, 1, 4'hF, 9'd7, 32'h11223344);
    cycle();
    set_req(1, 1, 4'h5, 9'd7, 32'hAABBCCDD);
    cycle();
    set_req(1, 0, 4'h0, 9'd7, 32'h0);
    cycle();
    set_req(0, 0, '0, '0, '0);
    cycle();
    cycle();
    chk("mask_valid", rsp_valid, 1);
    chk("mask_rdata", rsp_rdata, 32'h11BB33DD);
    drain();

    // Throughput: 8 back-to-back reads
    npop = 0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(1, 0, '0, AW'(i), '0);
      cycle();
    end
    chk("tp_accepts", nacc, 8);
    drain();
    chk("tp_pops", npop, 8);
    chk("tp_span", last_pop - first_pop, 7);

    // Back-pressure
    rsp_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(1, 0, '0, AW'(9'h40 + nacc), '0);
      cycle();
    end
    chk("bp_accepts", nacc, DEPTH);
    chk("bp_ready", req_ready, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && nacc < 6; i++) begin
      set_req(1, 0, '0, AW'(9'h40 + nacc), '0);
      cycle();
    end
    chk("bp_total", nacc, 6);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              NM'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
              $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset with a read in flight
    rsp_ready = 1'b0;
    set_req(1, 0, '0, 9'd3, '0);
    cycle();
    set_req(0, 0, '0, '0, '0);
    cycle();
    rstb0 = 1'b0;
    expq.delete();
    cycle();
    cycle();
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_csb0", csb0, 1);
    rstb0 = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) cycle();
    chk("post_rst_valid", rsp_valid, 0);

    // Write acknowledge (only present with the optional feature)
    set_req(1, 1, 4'hF, 9'd9, 32'hCAFEF00D);
    cycle();
    set_req(0, 0, '0, '0, '0);
    cycle();
    cycle();
    chk("wack_valid", rsp_valid, WACK);
    chk("wack_wr", rsp_wr, WACK);
    chk("wack_rdata", rsp_rdata, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
